// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, FSM state
// encoding and the ALUOp codes understood by the ALU decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_e;

endpackage

// File: rtl/main_control_outdec.sv
// Combinational decode of controller state (plus MemReady during FETCH)
// into datapath selects, write strobes and ALUOp.
module main_control_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       branch_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       trap_o
);

  always_comb begin
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    pc_src_o     = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALUOP_ADD;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    trap_o       = 1'b0;
    unique case (state_e'(state_i))
      // PC+4 is computed every FETCH cycle but only committed once memory answers.
      FETCH: begin
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE:  alu_src_b_o = 2'b11;
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      MEMRD:   iord_o = 1'b1;
      MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      MEMWR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_SUB;
        pc_src_o    = 2'b01;
        branch_o    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      ADDIWB:  reg_write_o = 1'b1;
      JUMP: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
      end
      TRAP:    trap_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: instruction sequencing FSM with a
// retired-instruction counter; output decode lives in main_control_outdec.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [5:0]           Op,
  input  logic                 MemReady,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic [1:0]           PCSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 Retired,
  output logic                 Trap,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  state_e               state_q, state_d;
  logic                 retired_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 retire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        unique case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:  state_d = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MemReady ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = MemReady ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // An instruction retires on the edge that returns the FSM to FETCH.
  assign retire = (state_q != FETCH) && (state_d == FETCH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= FETCH;
      retired_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retire;
      if (retire) count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign Retired    = retired_q;
  assign InstrCount = count_q;

  main_control_outdec u_outdec (
    .state_i      (state_q),
    .mem_ready_i  (MemReady),
    .iord_o       (IorD),
    .mem_write_o  (MemWrite),
    .ir_write_o   (IRWrite),
    .pc_write_o   (PCWrite),
    .branch_o     (Branch),
    .pc_src_o     (PCSrc),
    .alu_src_a_o  (ALUSrcA),
    .alu_src_b_o  (ALUSrcB),
    .alu_op_o     (ALUOp),
    .reg_dst_o    (RegDst),
    .mem_to_reg_o (MemtoReg),
    .reg_write_o  (RegWrite),
    .trap_o       (Trap)
  );

endmodule
